// File: rtl/adder_sum_accumulator_if.sv
// adder_sum_accumulator_if: sum input and block-result handshakes of the accumulator
interface adder_sum_accumulator_if #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 7
);
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] out_total;
    logic [SUM_W-1:0] out_max;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    modport master (
        output sum_in, sum_valid, out_ready,
        input  sum_ready, out_total, out_max, out_ovf, out_valid, busy
    );
    modport slave (
        input  sum_in, sum_valid, out_ready,
        output sum_ready, out_total, out_max, out_ovf, out_valid, busy
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: per-block saturated total, maximum and overflow of adder sums
module adder_sum_accumulator #(
    parameter int SUM_W     = 5,
    parameter int ACC_W     = 7,
    parameter int BLOCK_LEN = 4
) (
    input logic                    clk,
    input logic                    rst,
    adder_sum_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [SUM_W-1:0] max_r, max_n;
    logic             ovf, ovf_n;
    logic [7:0]       cnt, cnt_n;
    logic [ACC_W:0]   sum_x;
    assign sum_x = {1'b0, acc} + (ACC_W + 1)'(bus.sum_in);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            max_r <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            max_r <= max_n;
            ovf   <= ovf_n;
            cnt   <= cnt_n;
        end
    end
    // ready/valid come from state alone, so a transfer is just sum_valid outside HOLD
    always_comb begin
        state_n = state;
        acc_n   = acc;
        max_n   = max_r;
        ovf_n   = ovf;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.sum_valid) begin
                acc_n   = ACC_W'(bus.sum_in);
                max_n   = bus.sum_in;
                ovf_n   = 1'b0;
                cnt_n   = 8'd1;
                state_n = (BLOCK_LEN == 1) ? HOLD : ACCUM;
            end
            ACCUM: if (bus.sum_valid) begin
                acc_n   = sum_x[ACC_W] ? '1 : sum_x[ACC_W-1:0];
                max_n   = (bus.sum_in > max_r) ? bus.sum_in : max_r;
                ovf_n   = ovf | sum_x[ACC_W];
                cnt_n   = cnt + 8'd1;
                state_n = (cnt_n == 8'(BLOCK_LEN)) ? HOLD : ACCUM;
            end
            HOLD: state_n = bus.out_ready ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end
    assign bus.sum_ready = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state == ACCUM);
    assign bus.out_total = acc;
    assign bus.out_max   = max_r;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb_adder_sum_accumulator: directed checks on BLOCK_LEN 4, 8 and 1 instances
module tb_adder_sum_accumulator;
    logic clk = 1'b0;
    logic rst;
    logic sv, ordy;
    logic [4:0] si;
    int sel;
    int vectors = 0;
    int errors = 0;
    logic o_rdy, o_valid, o_busy, o_ovf;
    logic [6:0] o_total;
    logic [4:0] o_max;

    always #5 clk = ~clk;

    adder_sum_accumulator_if #(.SUM_W(5), .ACC_W(7)) b4 ();
    adder_sum_accumulator_if #(.SUM_W(5), .ACC_W(7)) b8 ();
    adder_sum_accumulator_if #(.SUM_W(5), .ACC_W(7)) b1 ();

    adder_sum_accumulator #(.SUM_W(5), .ACC_W(7), .BLOCK_LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    adder_sum_accumulator #(.SUM_W(5), .ACC_W(7), .BLOCK_LEN(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    adder_sum_accumulator #(.SUM_W(5), .ACC_W(7), .BLOCK_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // sel routes the shared stimulus to one instance and its outputs back
    assign b4.sum_in = si;
    assign b8.sum_in = si;
    assign b1.sum_in = si;
    assign b4.sum_valid = (sel == 0) ? sv : 1'b0;
    assign b8.sum_valid = (sel == 1) ? sv : 1'b0;
    assign b1.sum_valid = (sel == 2) ? sv : 1'b0;
    assign b4.out_ready = (sel == 0) ? ordy : 1'b0;
    assign b8.out_ready = (sel == 1) ? ordy : 1'b0;
    assign b1.out_ready = (sel == 2) ? ordy : 1'b0;

    always_comb begin
        o_rdy   = (sel == 0) ? b4.sum_ready : (sel == 1) ? b8.sum_ready : b1.sum_ready;
        o_valid = (sel == 0) ? b4.out_valid : (sel == 1) ? b8.out_valid : b1.out_valid;
        o_busy  = (sel == 0) ? b4.busy      : (sel == 1) ? b8.busy      : b1.busy;
        o_ovf   = (sel == 0) ? b4.out_ovf   : (sel == 1) ? b8.out_ovf   : b1.out_ovf;
        o_total = (sel == 0) ? b4.out_total : (sel == 1) ? b8.out_total : b1.out_total;
        o_max   = (sel == 0) ? b4.out_max   : (sel == 1) ? b8.out_max   : b1.out_max;
    end

    task automatic send(input logic [4:0] v);
        int n = 0;
        sv = 1'b1;
        si = v;
        while (o_rdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            errors++;
            $display("FAIL send_timeout got sum_ready=%b want 1", o_rdy);
        end
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic collect(output logic [6:0] t, output logic [4:0] m, output logic f);
        int n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout got out_valid=%b want 1", o_valid);
        end
        t = o_total;
        m = o_max;
        f = o_ovf;
    endtask

    task automatic release_out();
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({o_rdy, o_valid, o_busy, o_total, o_max, o_ovf} !== {1'b1, 1'b0, 1'b0, 7'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b val=%b busy=%b tot=%0d max=%0d ovf=%b want 1 0 0 0 0 0",
                     o_rdy, o_valid, o_busy, o_total, o_max, o_ovf);
        end
    endtask

    task automatic test_basic();
        logic [6:0] t; logic [4:0] m; logic f;
        sel = 0;
        send(5'd0); send(5'd2); send(5'd9);
        vectors++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_early got val=%b busy=%b want 0 1", o_valid, o_busy);
        end
        send(5'd18);
        vectors++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got out_valid=%b want 1", o_valid);
        end
        collect(t, m, f);
        vectors++;
        if ({t, m, f} !== {7'd29, 5'd18, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got %0d/%0d/%b want 29/18/0", t, m, f);
        end
        release_out();
        vectors++;
        if (o_rdy !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_recover got rdy=%b val=%b want 1 0", o_rdy, o_valid);
        end
    endtask

    task automatic test_gaps_hold();
        logic [6:0] t; logic [4:0] m; logic f;
        sel = 0;
        send(5'd0); repeat (1) @(negedge clk);
        send(5'd2);
        send(5'd9); repeat (3) @(negedge clk);
        send(5'd18);
        collect(t, m, f);
        vectors++;
        if ({t, m, f} !== {7'd29, 5'd18, 1'b0}) begin
            errors++;
            $display("FAIL gaps_result got %0d/%0d/%b want 29/18/0", t, m, f);
        end
        sv = 1'b1;
        si = 5'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({o_rdy, o_valid, o_total, o_max, o_ovf} !== {1'b0, 1'b1, 7'd29, 5'd18, 1'b0}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got rdy=%b val=%b %0d/%0d/%b want 0 1 29/18/0",
                         i, o_rdy, o_valid, o_total, o_max, o_ovf);
            end
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        vectors++;
        if ({o_rdy, o_valid, o_busy} !== 3'b100) begin
            errors++;
            $display("FAIL hold_release got rdy=%b val=%b busy=%b want 1 0 0", o_rdy, o_valid, o_busy);
        end
        @(negedge clk);
        sv = 1'b0;
        vectors++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stalled_accept got busy=%b want 1", o_busy);
        end
        send(5'd1); send(5'd1); send(5'd1);
        collect(t, m, f);
        vectors++;
        if ({t, m, f} !== {7'd10, 5'd7, 1'b0}) begin
            errors++;
            $display("FAIL stalled_block got %0d/%0d/%b want 10/7/0", t, m, f);
        end
        release_out();
    endtask

    task automatic test_saturate();
        logic [6:0] t; logic [4:0] m; logic f;
        sel = 1;
        for (int i = 0; i < 8; i++) send(5'd30);
        collect(t, m, f);
        vectors++;
        if ({t, m, f} !== {7'd127, 5'd30, 1'b1}) begin
            errors++;
            $display("FAIL sat_result got %0d/%0d/%b want 127/30/1", t, m, f);
        end
        release_out();
        for (int i = 0; i < 8; i++) send(5'd1);
        collect(t, m, f);
        vectors++;
        if ({t, m, f} !== {7'd8, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL sat_clear got %0d/%0d/%b want 8/1/0", t, m, f);
        end
        release_out();
    endtask

    task automatic test_single();
        logic [4:0] vals [2];
        vals[0] = 5'd16;
        vals[1] = 5'd30;
        sel = 2;
        ordy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(vals[i]);
            vectors++;
            if ({o_valid, o_total, o_max, o_ovf} !== {1'b1, 7'(vals[i]), vals[i], 1'b0}) begin
                errors++;
                $display("FAIL single_result %0d got val=%b %0d/%0d/%b want 1 %0d/%0d/0",
                         i, o_valid, o_total, o_max, o_ovf, vals[i], vals[i]);
            end
            @(negedge clk);
            vectors++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_pulse %0d got out_valid=%b want 0", i, o_valid);
            end
        end
        ordy = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [6:0] t; logic [4:0] m; logic f;
        sel = 0;
        send(5'd5); send(5'd5);
        rst = 1'b1;
        #1;
        vectors++;
        if ({o_busy, o_valid, o_rdy, o_total} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL reset_mid got busy=%b val=%b rdy=%b tot=%0d want 0 0 1 0", o_busy, o_valid, o_rdy, o_total);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(5'd1);
        collect(t, m, f);
        vectors++;
        if ({t, m, f} !== {7'd4, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset_block got %0d/%0d/%b want 4/1/0", t, m, f);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        sel = 0;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) send(5'd31);
        vectors++;
        if ({o_valid, o_total, o_max, o_ovf} !== {1'b1, 7'd124, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first got val=%b %0d/%0d/%b want 1 124/31/0", o_valid, o_total, o_max, o_ovf);
        end
        for (int i = 0; i < 4; i++) send(5'd0);
        vectors++;
        if ({o_valid, o_total, o_max, o_ovf} !== {1'b1, 7'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second got val=%b %0d/%0d/%b want 1 0/0/0", o_valid, o_total, o_max, o_ovf);
        end
        @(negedge clk);
        ordy = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got val=%b busy=%b want 0 0", o_valid, o_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        sv = 1'b0;
        si = '0;
        ordy = 1'b0;
        sel = 0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_gaps_hold();
        test_saturate();
        test_single();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
